// File: rtl/seq_divider_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_FRAC_BITS = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_dp.sv
// Datapath: operand capture, shift-subtract iteration and result fix-up
// (magnitude division, sign restore, saturation).
module seq_divider_dp
    import seq_divider_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_in,
    output logic [WIDTH-1:0] q_fin,
    output logic [WIDTH-1:0] r_fin,
    output logic             ovf_fin
);

    localparam int N = WIDTH + FRAC_BITS;
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] HALF    = ONE_N << (WIDTH - 1);
    localparam logic [N-1:0] POS_MAX = HALF - ONE_N;

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [N-1:0]     dq_q;
    logic [N-1:0]     dq_nxt;
    logic [N-1:0]     a_ext;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             smode_q;

    always_comb begin
        a_abs = (signed_in && a_in[WIDTH-1]) ? -a_in : a_in;
        b_abs = (signed_in && b_in[WIDTH-1]) ? -b_in : b_in;
        a_ext = '0;
        a_ext[WIDTH-1:0] = a_abs;
        a_ext = a_ext << FRAC_BITS;
    end

    // dq_q shifts dividend bits out the top and quotient bits in the bottom
    assign rem_sh          = {rem_q, dq_q[N-1]};
    assign {borrow, diff}  = {1'b0, rem_sh} - {2'b00, div_q};
    assign rem_nxt         = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dq_nxt          = {dq_q[N-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (sclr) begin
            div_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            smode_q <= 1'b0;
        end else if (load) begin
            div_q   <= b_abs;
            rem_q   <= '0;
            dq_q    <= a_ext;
            neg_q_q <= signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            neg_r_q <= signed_in & a_in[WIDTH-1];
            smode_q <= signed_in;
        end else if (step) begin
            rem_q <= rem_nxt;
            dq_q  <= dq_nxt;
        end
    end

    // Evaluated on the final iteration's next values so DONE needs no extra cycle
    always_comb begin
        ovf_fin = 1'b0;
        q_fin   = dq_nxt[WIDTH-1:0];
        r_fin   = neg_r_q ? -rem_nxt : rem_nxt;
        if (!smode_q) begin
            if ((dq_nxt >> WIDTH) != '0) begin
                ovf_fin = 1'b1;
                q_fin   = '1;
            end
        end else if (neg_q_q) begin
            if (dq_nxt > HALF) begin
                ovf_fin = 1'b1;
                q_fin   = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                q_fin = -dq_nxt[WIDTH-1:0];
            end
        end else if (dq_nxt > POS_MAX) begin
            ovf_fin = 1'b1;
            q_fin   = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN to add signed_in (two's-complement mode).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_in,
`endif
    output logic             busy,
    output logic             valid,
    output logic             dvz,
    output logic             ovf,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out
);

    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            smode;
    logic            b_zero;
    logic            accept;
    logic            load;
    logic            finish;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic            ovf_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign smode = signed_in;
`else
    assign smode = 1'b0;
`endif

    assign b_zero = (b_in == '0);
    assign accept = start && (state_q != RUN);
    assign load   = accept && !b_zero;
    assign finish = (state_q == RUN) && (cnt_q == ONE_CNT);
    assign busy   = (state_q == RUN);
    assign valid  = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (b_zero) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = N_CNT;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - ONE_CNT;
                if (cnt_q == ONE_CNT) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Quotient/remainder hold across a new start until its result lands
    always_ff @(posedge clk) begin
        if (sclr) begin
            q_out <= '0;
            r_out <= '0;
            dvz   <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            dvz <= b_zero;
            ovf <= 1'b0;
            if (b_zero) begin
                q_out <= '0;
                r_out <= '0;
            end
        end else if (finish) begin
            q_out <= q_fin;
            r_out <= r_fin;
            ovf   <= ovf_fin;
        end
    end

    seq_divider_dp #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_dp (
        .clk       (clk),
        .sclr      (sclr),
        .load      (load),
        .step      (busy),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_in (smode),
        .q_fin     (q_fin),
        .r_fin     (r_fin),
        .ovf_fin   (ovf_fin)
    );

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: two instances (FRAC_BITS 0 and 4) against an arithmetic model.
module tb_seq_divider;

    localparam int W = 10;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic sclr;
    logic [1:0]        start_v;
    logic [1:0][W-1:0] a_v;
    logic [1:0][W-1:0] b_v;
    logic [1:0]        sm_v;
    logic [1:0]        busy_v;
    logic [1:0]        valid_v;
    logic [1:0]        dvz_v;
    logic [1:0]        ovf_v;
    logic [1:0][W-1:0] q_v;
    logic [1:0][W-1:0] r_v;

    logic [W-1:0] prev_q [2];
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    bit           op_sm [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W), .FRAC_BITS(0)) u0 (
        .clk       (clk),
        .sclr      (sclr),
        .start     (start_v[0]),
        .a_in      (a_v[0]),
        .b_in      (b_v[0]),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_in (sm_v[0]),
`endif
        .busy      (busy_v[0]),
        .valid     (valid_v[0]),
        .dvz       (dvz_v[0]),
        .ovf       (ovf_v[0]),
        .q_out     (q_v[0]),
        .r_out     (r_v[0])
    );

    seq_divider #(.WIDTH(W), .FRAC_BITS(4)) u1 (
        .clk       (clk),
        .sclr      (sclr),
        .start     (start_v[1]),
        .a_in      (a_v[1]),
        .b_in      (b_v[1]),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_in (sm_v[1]),
`endif
        .busy      (busy_v[1]),
        .valid     (valid_v[1]),
        .dvz       (dvz_v[1]),
        .ovf       (ovf_v[1]),
        .q_out     (q_v[1]),
        .r_out     (r_v[1])
    );

    function automatic int frac(input int sel);
        return (sel == 1) ? 4 : 0;
    endfunction

    task automatic check(input string tag, input int sel,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d: got %0d expected %0d", tag, sel, obs, exp);
    endtask

    // Q = trunc(A*2^F / B), R = A*2^F - Q*B, then clamp Q to the output range
    function automatic void model(input int f, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input bit sm,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output bit edvz, output bit eovf);
        longint av, bv, num, q, r, qmax, qmin;
        eq = '0;
        er = '0;
        edvz = 1'b0;
        eovf = 1'b0;
        if (b == '0) begin
            edvz = 1'b1;
            return;
        end
        av   = sm ? longint'($signed(a)) : longint'(a);
        bv   = sm ? longint'($signed(b)) : longint'(b);
        num  = av * (longint'(1) << f);
        q    = num / bv;
        r    = num - q * bv;
        qmax = sm ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
        qmin = sm ? -(longint'(1) << (W - 1)) : 0;
        if (q > qmax) begin
            eovf = 1'b1;
            q = qmax;
        end
        if (q < qmin) begin
            eovf = 1'b1;
            q = qmin;
        end
        eq = q[W-1:0];
        er = r[W-1:0];
    endfunction

    task automatic launch(input int sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit sm);
        a_v[sel]     = a;
        b_v[sel]     = b;
        sm_v[sel]    = sm;
        start_v[sel] = 1'b1;
        op_a[sel]    = a;
        op_b[sel]    = b;
        op_sm[sel]   = sm;
    endtask

    // Call with start already driven; returns #1 after the valid edge
    task automatic collect(input int sel, input bit hold);
        logic [W-1:0] eq, er;
        bit edvz, eovf;
        int n, lat, bcyc;
        n = W + frac(sel);
        model(frac(sel), op_a[sel], op_b[sel], op_sm[sel], eq, er, edvz, eovf);
        @(posedge clk);
        #1;
        if (!hold) start_v[sel] = 1'b0;
        a_v[sel]  = W'($urandom);
        b_v[sel]  = W'($urandom);
        sm_v[sel] = 1'($urandom);
        if (!edvz) begin
            check("accept_dvz_clr", sel, dvz_v[sel], 0);
            check("accept_ovf_clr", sel, ovf_v[sel], 0);
            check("accept_q_hold", sel, q_v[sel], prev_q[sel]);
        end
        lat  = 0;
        bcyc = 0;
        while (!valid_v[sel] && lat < 200) begin
            if (busy_v[sel]) bcyc++;
            if (hold && lat == n - 1) start_v[sel] = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", sel, lat, edvz ? 0 : n);
        check("busy_cycles", sel, bcyc, edvz ? 0 : n);
        check("q_out", sel, q_v[sel], eq);
        check("r_out", sel, r_v[sel], er);
        check("dvz", sel, dvz_v[sel], edvz);
        check("ovf", sel, ovf_v[sel], eovf);
        prev_q[sel] = eq;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [W-1:0] ra, rb;
        bit rs;
        sclr    = 1'b1;
        start_v = '0;
        a_v     = '0;
        b_v     = '0;
        sm_v    = '0;
        prev_q[0] = '0;
        prev_q[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", s, busy_v[s], 0);
            check("rst_valid", s, valid_v[s], 0);
            check("rst_dvz", s, dvz_v[s], 0);
            check("rst_ovf", s, ovf_v[s], 0);
            check("rst_q", s, q_v[s], 0);
            check("rst_r", s, r_v[s], 0);
        end
        sclr = 1'b0;

        @(negedge clk);
        launch(0, 10'd1000, 10'd7, 1'b0);
        collect(0, 1'b0);
        check("ex_1000_7_q", 0, q_v[0], 142);
        check("ex_1000_7_r", 0, r_v[0], 6);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 0, valid_v[0], 0);
        check("q_held_idle", 0, q_v[0], 142);

        @(negedge clk);
        launch(0, 10'd55, 10'd0, 1'b0);
        collect(0, 1'b0);
        check("dvz_flag", 0, dvz_v[0], 1);

        @(negedge clk);
        launch(1, 10'd3, 10'd2, 1'b0);
        collect(1, 1'b0);
        check("frac_3_2_q", 1, q_v[1], 24);
        @(negedge clk);
        launch(1, 10'd1023, 10'd1, 1'b0);
        collect(1, 1'b0);
        check("frac_ovf_flag", 1, ovf_v[1], 1);
        check("frac_ovf_q", 1, q_v[1], 1023);

        if (SB) begin
            @(negedge clk);
            launch(0, W'(-7), 10'd2, 1'b1);
            collect(0, 1'b0);
            check("s_m7_2_q", 0, q_v[0], 10'h3FD);
            check("s_m7_2_r", 0, r_v[0], 10'h3FF);
            @(negedge clk);
            launch(0, W'(-512), W'(-1), 1'b1);
            collect(0, 1'b0);
            check("s_ovf_flag", 0, ovf_v[0], 1);
            check("s_ovf_q", 0, q_v[0], 511);
        end

        @(negedge clk);
        launch(0, 10'd777, 10'd13, 1'b0);
        collect(0, 1'b1);

        @(negedge clk);
        launch(0, 10'd500, 10'd9, 1'b0);
        collect(0, 1'b0);
        launch(0, 10'd1023, 10'd3, 1'b0);
        collect(0, 1'b0);

        @(negedge clk);
        launch(0, 10'd900, 10'd5, 1'b0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_run_busy", 0, busy_v[0], 1);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        check("sclr_busy", 0, busy_v[0], 0);
        check("sclr_valid", 0, valid_v[0], 0);
        check("sclr_dvz", 0, dvz_v[0], 0);
        check("sclr_ovf", 0, ovf_v[0], 0);
        check("sclr_q", 0, q_v[0], 0);
        check("sclr_r", 0, r_v[0], 0);
        prev_q[0] = '0;
        prev_q[1] = '0;

        @(negedge clk);
        sclr = 1'b1;
        launch(0, 10'd100, 10'd0, 1'b0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        sclr = 1'b0;
        check("sclr_prio_valid", 0, valid_v[0], 0);
        check("sclr_prio_dvz", 0, dvz_v[0], 0);

        @(negedge clk);
        launch(0, 10'd100, 10'd3, 1'b0);
        collect(0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            ra  = W'($urandom);
            if ($urandom_range(0, 4) == 0) rb = '0;
            else if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(1, 7));
            else rb = W'($urandom);
            rs = SB ? 1'($urandom) : 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            launch(sel, ra, rb, rs);
            collect(sel, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
